// File: rtl/maq_ms.sv
`timescale 1ns/1ps
// Minutes/seconds stage of the clock: 1 Hz prescaler, BCD mm:ss (00:00-59:59)
// with RUN/SET modes and a one-cycle hour-increment pulse toward the hour machine.
module maq_ms #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       maqms_clock,
    input  logic       maqms_reset,
    input  logic       maqms_enable,
    input  logic       maqms_ajuste,
    input  logic       maqms_btn_min,
    input  logic       maqms_btn_hora,
    output logic [3:0] maqms_seg_lsd,
    output logic [2:0] maqms_seg_msd,
    output logic [3:0] maqms_min_lsd,
    output logic [2:0] maqms_min_msd,
    output logic       maqms_tick,
    output logic       maqms_inc_hora
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic {RUN = 1'b0, SET = 1'b1} mode_t;

    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    seg_lsd_q, seg_lsd_d;
    logic [2:0]    seg_msd_q, seg_msd_d;
    logic [3:0]    min_lsd_q, min_lsd_d;
    logic [2:0]    min_msd_q, min_msd_d;
    logic          tick_q, tick_d;
    logic          inc_q, inc_d;

    // Advance a 00-59 BCD pair; result is {wrap, msd, lsd}.
    function automatic logic [7:0] bcd60_inc(input logic [2:0] msd, input logic [3:0] lsd);
        logic       wrap;
        logic [2:0] m;
        logic [3:0] l;
        wrap = 1'b0;
        m    = msd;
        l    = lsd + 4'd1;
        if (lsd == 4'd9) begin
            l = 4'd0;
            if (msd == 3'd5) begin
                m    = 3'd0;
                wrap = 1'b1;
            end else begin
                m = msd + 3'd1;
            end
        end
        return {wrap, m, l};
    endfunction

    logic [7:0] seg_next, min_next;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        mode_d    = maqms_ajuste ? SET : RUN;
        presc_d   = presc_q;
        seg_lsd_d = seg_lsd_q;
        seg_msd_d = seg_msd_q;
        min_lsd_d = min_lsd_q;
        min_msd_d = min_msd_q;
        tick_d    = 1'b0;
        inc_d     = 1'b0;
        seg_next  = bcd60_inc(seg_msd_q, seg_lsd_q);
        min_next  = bcd60_inc(min_msd_q, min_lsd_q);

        if (mode_q == RUN && maqms_ajuste) begin
            // Entering SET: a coincident tick is discarded, seconds restart at 00.
            presc_d   = '0;
            seg_lsd_d = 4'd0;
            seg_msd_d = 3'd0;
        end else if (mode_q == SET && !maqms_ajuste) begin
            presc_d = '0;
        end else if (mode_q == SET) begin
            presc_d   = '0;
            seg_lsd_d = 4'd0;
            seg_msd_d = 3'd0;
            if (maqms_btn_min) begin
                min_msd_d = min_next[6:4];
                min_lsd_d = min_next[3:0];
            end
            inc_d = maqms_btn_hora;
        end else if (maqms_enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d   = '0;
                tick_d    = 1'b1;
                seg_msd_d = seg_next[6:4];
                seg_lsd_d = seg_next[3:0];
                if (seg_next[7]) begin
                    min_msd_d = min_next[6:4];
                    min_lsd_d = min_next[3:0];
                    inc_d     = min_next[7];
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge maqms_clock) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!maqms_reset) begin
            mode_q    <= RUN;
            presc_q   <= '0;
            seg_lsd_q <= 4'd0;
            seg_msd_q <= 3'd0;
            min_lsd_q <= 4'd0;
            min_msd_q <= 3'd0;
            tick_q    <= 1'b0;
            inc_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            seg_lsd_q <= seg_lsd_d;
            seg_msd_q <= seg_msd_d;
            min_lsd_q <= min_lsd_d;
            min_msd_q <= min_msd_d;
            tick_q    <= tick_d;
            inc_q     <= inc_d;
        end
    end

    assign maqms_seg_lsd  = seg_lsd_q;
    assign maqms_seg_msd  = seg_msd_q;
    assign maqms_min_lsd  = min_lsd_q;
    assign maqms_min_msd  = min_msd_q;
    assign maqms_tick     = tick_q;
    assign maqms_inc_hora = inc_q;

endmodule

// File: doc/maq_ms.md
# maq_ms

Minutes/seconds stage of the clock. Divides the system clock into a 1 Hz tick and keeps BCD seconds and minutes, 00:00 to 59:59. Produces the single-cycle carry pulse that drives the hour machine's increment input. A set mode lets the user advance minutes directly and request hour increments.

## Interface
Parameters:
- CLK_FREQ, default 50_000_000: system clock cycles per second. Legal range ≥ 2. The prescaler is $clog2(CLK_FREQ) bits wide.

Ports:
- maqms_clock  in  1  system clock; all state updates on the rising edge.
- maqms_reset  in  1  reset, synchronous, active-low.
- maqms_enable  in  1  run enable. When low, prescaler and time are frozen in RUN.
- maqms_ajuste  in  1  level. 1 = SET mode, 0 = RUN mode.
- maqms_btn_min  in  1  one-cycle pulse, already debounced: add one minute (SET only).
- maqms_btn_hora  in  1  one-cycle pulse, already debounced: add one hour (SET only).
- maqms_seg_lsd  out  4  seconds units, BCD 0–9.
- maqms_seg_msd  out  3  seconds tens, 0–5.
- maqms_min_lsd  out  4  minutes units, BCD 0–9.
- maqms_min_msd  out  3  minutes tens, 0–5.
- maqms_tick  out  1  registered 1 Hz pulse, high for one cycle per second.
- maqms_inc_hora  out  1  registered one-cycle pulse; connects to the hour machine's increment input.

## Operation
- Reset: the following are all 0 on the first edge with reset low. Reset overrides everything, mid-operation included.
  - all four digits
  - prescaler
  - maqms_tick
  - maqms_inc_hora
  - mode register (RUN)
- Mode register follows maqms_ajuste with one cycle of registration. States are RUN and SET.
- RUN → SET (ajuste rises): on the transition edge, prescaler clears, seconds clear to 00, minutes are held.
- SET → RUN (ajuste falls): prescaler clears. The first tick comes CLK_FREQ enabled cycles later.
- RUN, enable=1:
  - The prescaler increments each cycle.
  - On the edge where prescaler == CLK_FREQ-1: prescaler ← 0, maqms_tick ← 1, seconds advance.
- Seconds advance:
  - lsd 9 → 0 with msd+1.
  - 59 → 00, which also advances minutes.
- Minutes advance:
  - lsd 9 → 0 with msd+1.
  - 59 → 00, which also sets maqms_inc_hora ← 1 on the same edge.
- RUN, enable=0: prescaler, digits and outputs are held; tick and inc_hora are 0. Buttons are ignored in RUN.
- SET:
  - No ticks. Seconds stay at 00. The prescaler is held at 0 regardless of enable.
  - btn_min: minutes advance with wrap 59 → 00. No inc_hora is generated on this wrap.
  - btn_hora: maqms_inc_hora ← 1 for one cycle.
  - Both buttons in the same cycle: both actions occur on that edge.
- Digits never leave legal BCD ranges. Illegal values are not reachable from reset.
- All additions are done within the digit widths. No intermediate binary counter is used for time.

## Timing
- Outputs are registered, so tick, inc_hora and digits change on the same edge.
- After reset release with enable=1, the first tick is high in the cycle following edge number CLK_FREQ.
- Tick period is exactly CLK_FREQ cycles while enable stays 1. Enable low stretches the period by the number of disabled cycles.
- inc_hora in RUN:
  - Coincides with tick on the 59:59 → 00:00 edge.
  - The hour machine updates one edge later.
- inc_hora in SET: high in the cycle after the btn_hora pulse edge.
- Button pulses longer than one cycle add one unit per high cycle. The debouncer upstream guarantees single-cycle pulses.
- Mode change and tick on the same edge: the mode change wins. Prescaler clears, no tick, no time advance.

## Test plan
- CLK_FREQ=4, reset low 2 cycles, then enable=1 for 20 cycles:
  - all outputs 0 during reset;
  - tick pulses after edges 4, 8, 12, 16, 20;
  - seconds read 01..05.
- Preload to 59:58 by stepping, run 2 ticks: 59:59, then 00:00 with tick=1 and inc_hora=1 in the same cycle. inc_hora is 0 the next cycle.
- enable=0 for 10 cycles mid-count (prescaler=2): no tick, digits unchanged. On re-enable the next tick comes 2 cycles later.
- ajuste=1 at 12:34: seconds become 00, minutes stay 12.
  - btn_min ×48: minutes read 00.
  - inc_hora never fires on that wrap.
  - btn_hora once: a single inc_hora pulse.
- ajuste=1 with btn_min and btn_hora in the same cycle at 07: minutes 08 and one inc_hora pulse.
- Reset low asserted at 45:59 one cycle before a tick: next cycle all digits, tick and inc_hora are 0, and the mode is RUN.
